core_pipe_issue: RTL and testbench
==================================

Name: core_pipe_issue

Overview:
- Parametrised decode-to-execute issue stage. Sits between the operand-gather decoder and execute (s3).
- Buffers decoded, operand-gathered instructions in a small FIFO with a valid/ready handshake in both directions.
- Holds a register scoreboard that stalls issue on RAW/WAW hazards against long-latency units (LSU, MDU).
- Discards buffered work on a control-flow flush.

Parameters:
- XLEN, 64, data/PC width.
- RA_W, 5, register address width.
- OP_W, 5, per-unit opcode width.
- UNIT_N, 5, functional-unit count; the unit select is one-hot.
- LONG_MASK, 5'b00110, units whose writeback is tracked by the scoreboard (bit1 LSU, bit2 MDU).
- DEPTH, 2, FIFO entries, power of two and at least 2.

Ports:
- g_clk  in  1  global clock.
- g_reset  in  1  reset.
- flush  in  1  control-flow change acknowledged; discard the buffer and the current input.
- d_valid  in  1  decoded instruction valid.
- d_ready  out  1  issue accepts the instruction.
- d_pc  in  XLEN  instruction PC.
- d_rs1_addr, d_rs2_addr  in  RA_W  source registers.
- d_rs1_use, d_rs2_use  in  1  the source is read.
- d_rd  in  RA_W  destination register.
- d_opr_a, d_opr_b, d_opr_c  in  XLEN  gathered operands.
- d_unit  in  UNIT_N  one-hot unit select.
- d_op  in  OP_W  unit opcode.
- d_op_w  in  1  32-bit word operation.
- d_instr  in  33  raw instruction plus a 16/32-bit flag.
- wb_valid  in  1  a long-latency writeback completes.
- wb_rd  in  RA_W  writeback destination.
- s2_valid  out  1  FIFO head valid.
- s3_ready  in  1  execute accepts the head.
- s2_pc, s2_opr_a, s2_opr_b, s2_opr_c  out  XLEN  head fields.
- s2_rd  out  RA_W  head destination.
- s2_unit  out  UNIT_N  head unit select.
- s2_op  out  OP_W  head opcode.
- s2_op_w  out  1  head word-operation flag.
- s2_instr  out  33  head raw instruction.
- perf_stall  out  32  hazard-stall cycle count (optional feature).
- perf_flush  out  32  flush count (optional feature).

Behaviour:
- Clocking and reset: one clock g_clk; reset g_reset is synchronous and active-high.
- Reset state: FIFO empty, scoreboard all clear, counters zero.
- Reset outputs: s2_valid=0 and every s2_* data output = 0.
- A reset asserted mid-operation drops all entries and all pending bits in the same edge.
- Hazard definition: hazard = (d_rs1_use & pend(rs1)) | (d_rs2_use & pend(rs2)) | pend(rd).
- pend(r) is true when r!=0 and either:
  - scoreboard bit r is set, or
  - any valid FIFO entry has rd==r and (unit & LONG_MASK)!=0.
- Handshake in: d_ready = !flush & !hazard & (count<DEPTH).
  - Enqueue on d_valid & d_ready.
  - d_ready may depend combinationally on d_rs*/d_rd.
- Handshake out: s2_valid = count!=0. The head is dequeued on s2_valid & s3_ready.
- Latency: an instruction enqueued at edge N is visible on s2_* after edge N.
  - No combinational path from d_* to s2_*.
- Throughput: simultaneous enqueue and dequeue keeps count unchanged.
  - Full throughput requires DEPTH >= 2 and no hazards.
- Full/empty: count saturates at DEPTH (d_ready=0). Dequeue is never attempted when empty.
- Pointers: read and write pointers wrap modulo DEPTH. Count is log2(DEPTH)+1 bits.
- Scoreboard set: on dequeue of an entry with rd!=0 and (unit & LONG_MASK)!=0, set bit rd.
- Scoreboard clear: on wb_valid with wb_rd!=0, clear bit wb_rd.
- Simultaneous set and clear of the same register in one cycle: set wins.
- Register x0 is never pending.
- Flush:
  - At the next edge, count=0 and pointers reset; d_ready=0 during the flush cycle.
  - The scoreboard is untouched: in-flight long ops still write back.
  - A dequeue in the flush cycle still completes, and its scoreboard set still applies.
- Output holding: s2_* are held stable while s2_valid & !s3_ready.

Optional Feature:
- Macro: CORE_ISSUE_PERF_EN.
- When defined:
  - perf_stall increments each cycle d_valid & hazard & !flush.
  - perf_flush increments on each flush cycle.
  - Both wrap at 2^32 and clear on reset.
- When undefined: both outputs are tied to 0 and no counter flops exist.

Decomposition:
- Shared constants in core_common.vh: unit one-hot indices (ALU, LSU, MDU, CSR, CFU), default LONG_MASK, OP_W, RA_W.
- Sub-module core_issue_fifo: a generic DEPTH x payload FIFO.
  - Exposes per-entry valid, rd and long flags for the hazard compare.
- The scoreboard and hazard logic stay in the top module.

Test Plan:
- Back-to-back: 8 independent ALU ops (unit=5'b00001) with s3_ready=1 -> one issue per cycle; s2_pc sequence 0x100, 0x104, ..., each one cycle after enqueue.
- Load-use stall:
  - Stimulus: load rd=5 (unit=LSU) dequeued, then add with rs1=5.
  - Required: d_ready=0 until wb_valid with wb_rd=5; the add is enqueued the cycle after writeback.
  - With CORE_ISSUE_PERF_EN, perf_stall equals the stall cycles.
- Backpressure: s3_ready=0 for 4 cycles while feeding 3 ops -> count reaches 2, d_ready=0, s2_* held at the first op; release drains in order.
- Flush mid-stream: 2 entries buffered, flush=1 with d_valid=1 -> next cycle s2_valid=0, the input is not taken, scoreboard bit 7 from an earlier MDU op is still set.
- Set/clear collision: dequeue MDU rd=9 in the same cycle as wb_valid wb_rd=9 -> bit 9 remains set.
- x0 and reset: an MDU op with rd=0 never stalls rs1=0 readers. g_reset mid-drain -> s2_valid=0 and the scoreboard is clear next cycle.

Source files
------------

// File: rtl/core_pipe_issue_pkg.sv
// Shared constants for the decode-to-execute issue stage: functional-unit
// one-hot bit positions, the default set of long-latency units, and the
// default register/opcode field widths.
package core_pipe_issue_pkg;

  // Bit positions inside the one-hot unit select.
  localparam int UNIT_ALU = 0;
  localparam int UNIT_LSU = 1;
  localparam int UNIT_MDU = 2;
  localparam int UNIT_CSR = 3;
  localparam int UNIT_CFU = 4;

  localparam int UNIT_N_DEF = 5;
  localparam int RA_W_DEF   = 5;
  localparam int OP_W_DEF   = 5;
  localparam int INSTR_W    = 33;

  // Units whose writeback arrives later and must be tracked by the scoreboard.
  localparam logic [UNIT_N_DEF-1:0] LONG_MASK_DEF =
    UNIT_N_DEF'((1 << UNIT_LSU) | (1 << UNIT_MDU));

endpackage

// File: rtl/core_issue_fifo.sv
// Generic DEPTH x PW FIFO used as the issue buffer. Besides the head payload it
// exposes, per physical slot, a valid bit plus the destination register and a
// long-latency flag so the parent can compare hazards against buffered work.
// Flush and reset both empty the buffer at the next edge.
module core_issue_fifo #(
  parameter int DEPTH = 2,
  parameter int PW    = 8,
  parameter int RA_W  = 5
) (
  input  logic                       g_clk,
  input  logic                       g_reset,
  input  logic                       flush,
  input  logic                       wr_en,
  input  logic [PW-1:0]              wr_data,
  input  logic [RA_W-1:0]            wr_rd,
  input  logic                       wr_long,
  input  logic                       rd_en,
  output logic [$clog2(DEPTH):0]     count,
  output logic [PW-1:0]              rd_data,
  output logic [DEPTH-1:0]           ent_valid,
  output logic [DEPTH-1:0][RA_W-1:0] ent_rd,
  output logic [DEPTH-1:0]           ent_long
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PW-1:0]              mem [DEPTH];
  logic [DEPTH-1:0][RA_W-1:0] rd_tab;
  logic [DEPTH-1:0]           long_tab;
  logic [DEPTH-1:0]           vld;
  logic [PTR_W-1:0]           wr_ptr;
  logic [PTR_W-1:0]           rd_ptr;
  logic [CNT_W-1:0]           cnt;

  // Payload storage: written on enqueue only.
  // NOTE: storage is deliberately not reset; every consumer qualifies it with
  // vld/cnt, so stale contents are never observable and the array stays a
  // plain RAM without a reset fan-out.
  always_ff @(posedge g_clk) begin
    if (wr_en) begin
      mem[wr_ptr]      <= wr_data;
      rd_tab[wr_ptr]   <= wr_rd;
      long_tab[wr_ptr] <= wr_long;
    end
  end

  // Pointers, occupancy and per-slot valid bits; flush empties like reset.
  // NOTE: all state here uses non-blocking assignments so every read in this
  // block sees the pre-edge value regardless of statement order.
  always_ff @(posedge g_clk) begin
    if (g_reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      vld    <= '0;
    end else begin
      if (wr_en) begin
        vld[wr_ptr] <= 1'b1;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (rd_en) begin
        vld[rd_ptr] <= 1'b0;
        rd_ptr      <= rd_ptr + PTR_W'(1);
      end
      cnt <= cnt + CNT_W'(wr_en) - CNT_W'(rd_en);
    end
  end

  assign count     = cnt;
  assign ent_valid = vld;
  assign ent_rd    = rd_tab;
  assign ent_long  = long_tab;
  // Head is forced to zero when empty so the stage outputs are clean after reset.
  assign rd_data   = (cnt != '0) ? mem[rd_ptr] : '0;

endmodule

// File: rtl/core_pipe_issue.sv
// Decode-to-execute issue stage. Buffers operand-gathered instructions in a
// small FIFO, stalls intake on RAW/WAW hazards against long-latency units
// (scoreboard plus buffered long ops) and drops buffered work on a flush.
// Optional build macro CORE_ISSUE_PERF_EN adds stall/flush cycle counters;
// without it perf_stall/perf_flush are tied to zero.
module core_pipe_issue
  import core_pipe_issue_pkg::*;
#(
  parameter int                XLEN      = 64,
  parameter int                RA_W      = RA_W_DEF,
  parameter int                OP_W      = OP_W_DEF,
  parameter int                UNIT_N    = UNIT_N_DEF,
  parameter logic [UNIT_N-1:0] LONG_MASK = LONG_MASK_DEF,
  parameter int                DEPTH     = 2
) (
  input  logic                 g_clk,
  input  logic                 g_reset,
  input  logic                 flush,
  input  logic                 d_valid,
  output logic                 d_ready,
  input  logic [XLEN-1:0]      d_pc,
  input  logic [RA_W-1:0]      d_rs1_addr,
  input  logic [RA_W-1:0]      d_rs2_addr,
  input  logic                 d_rs1_use,
  input  logic                 d_rs2_use,
  input  logic [RA_W-1:0]      d_rd,
  input  logic [XLEN-1:0]      d_opr_a,
  input  logic [XLEN-1:0]      d_opr_b,
  input  logic [XLEN-1:0]      d_opr_c,
  input  logic [UNIT_N-1:0]    d_unit,
  input  logic [OP_W-1:0]      d_op,
  input  logic                 d_op_w,
  input  logic [INSTR_W-1:0]   d_instr,
  input  logic                 wb_valid,
  input  logic [RA_W-1:0]      wb_rd,
  output logic                 s2_valid,
  input  logic                 s3_ready,
  output logic [XLEN-1:0]      s2_pc,
  output logic [XLEN-1:0]      s2_opr_a,
  output logic [XLEN-1:0]      s2_opr_b,
  output logic [XLEN-1:0]      s2_opr_c,
  output logic [RA_W-1:0]      s2_rd,
  output logic [UNIT_N-1:0]    s2_unit,
  output logic [OP_W-1:0]      s2_op,
  output logic                 s2_op_w,
  output logic [INSTR_W-1:0]   s2_instr,
  output logic [31:0]          perf_stall,
  output logic [31:0]          perf_flush
);

  localparam int PW    = 4 * XLEN + RA_W + UNIT_N + OP_W + 1 + INSTR_W;
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int NREG  = 1 << RA_W;

  logic [PW-1:0]              wr_data;
  logic [PW-1:0]              head_data;
  logic [CNT_W-1:0]           count;
  logic [DEPTH-1:0]           ent_valid;
  logic [DEPTH-1:0]           ent_long;
  logic [DEPTH-1:0][RA_W-1:0] ent_rd;
  logic [NREG-1:0]            sb;
  logic [NREG-1:0]            sb_nxt;
  logic                       hazard;
  logic                       full;
  logic                       enq;
  logic                       deq;
  logic                       wr_long;
  logic                       head_long;

  // A register is pending if a long op already issued to it (scoreboard) or a
  // long op targeting it is still waiting in the buffer. x0 is never pending.
  function automatic logic pend(input logic [RA_W-1:0]            r,
                                input logic [NREG-1:0]            sbv,
                                input logic [DEPTH-1:0]           ev,
                                input logic [DEPTH-1:0]           el,
                                input logic [DEPTH-1:0][RA_W-1:0] er);
    logic p;
    p = sbv[r];
    for (int i = 0; i < DEPTH; i++) begin
      if (ev[i] && el[i] && (er[i] == r)) p = 1'b1;
    end
    return (r != '0) && p;
  endfunction

  assign hazard  = (d_rs1_use && pend(d_rs1_addr, sb, ent_valid, ent_long, ent_rd))
                || (d_rs2_use && pend(d_rs2_addr, sb, ent_valid, ent_long, ent_rd))
                || pend(d_rd, sb, ent_valid, ent_long, ent_rd);
  assign full    = (count == CNT_W'(DEPTH));
  assign d_ready = !flush && !hazard && !full;
  assign enq     = d_valid && d_ready;
  assign s2_valid = (count != '0);
  assign deq     = s2_valid && s3_ready;

  assign wr_long = |(d_unit & LONG_MASK);
  assign wr_data = {d_pc, d_opr_a, d_opr_b, d_opr_c, d_rd, d_unit, d_op, d_op_w, d_instr};

  core_issue_fifo #(
    .DEPTH (DEPTH),
    .PW    (PW),
    .RA_W  (RA_W)
  ) u_fifo (
    .g_clk     (g_clk),
    .g_reset   (g_reset),
    .flush     (flush),
    .wr_en     (enq),
    .wr_data   (wr_data),
    .wr_rd     (d_rd),
    .wr_long   (wr_long),
    .rd_en     (deq),
    .count     (count),
    .rd_data   (head_data),
    .ent_valid (ent_valid),
    .ent_rd    (ent_rd),
    .ent_long  (ent_long)
  );

  assign {s2_pc, s2_opr_a, s2_opr_b, s2_opr_c, s2_rd, s2_unit, s2_op, s2_op_w, s2_instr} = head_data;
  assign head_long = |(s2_unit & LONG_MASK);

  // Next scoreboard: writeback clears first, so an issue to the same register
  // in the same cycle leaves the bit set. Flush does not touch it.
  // NOTE: sb_nxt takes a full default before any conditional update, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    sb_nxt = sb;
    if (wb_valid) sb_nxt[wb_rd] = 1'b0;
    if (deq && head_long) sb_nxt[s2_rd] = 1'b1;
    sb_nxt[0] = 1'b0;
  end

  // Scoreboard register.
  always_ff @(posedge g_clk) begin
    if (g_reset) sb <= '0;
    else         sb <= sb_nxt;
  end

`ifdef CORE_ISSUE_PERF_EN
  logic [31:0] stall_q;
  logic [31:0] flush_q;

  // Hazard-stall and flush cycle counters, free-running with natural wrap.
  always_ff @(posedge g_clk) begin
    if (g_reset) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (d_valid && hazard && !flush) stall_q <= stall_q + 32'd1;
      if (flush)                       flush_q <= flush_q + 32'd1;
    end
  end

  assign perf_stall = stall_q;
  assign perf_flush = flush_q;
`else
  assign perf_stall = '0;
  assign perf_flush = '0;
`endif

endmodule

// File: tb/tb_core_pipe_issue.sv
// Self-checking bench for core_pipe_issue: directed scenarios followed by
// randomized traffic, all compared cycle by cycle against a queue-based model.
module tb_core_pipe_issue;

  localparam int          XLEN  = 64;
  localparam int          DEPTH = 2;
  localparam logic [4:0]  LMASK = 5'b00110;
  localparam logic [4:0]  U_ALU = 5'b00001;
  localparam logic [4:0]  U_LSU = 5'b00010;
  localparam logic [4:0]  U_MDU = 5'b00100;

  logic             g_clk = 1'b0;
  logic             g_reset, flush, d_valid, d_ready;
  logic [XLEN-1:0]  d_pc, d_opr_a, d_opr_b, d_opr_c;
  logic [4:0]       d_rs1_addr, d_rs2_addr, d_rd, d_unit, d_op;
  logic             d_rs1_use, d_rs2_use, d_op_w;
  logic [32:0]      d_instr;
  logic             wb_valid;
  logic [4:0]       wb_rd;
  logic             s2_valid, s3_ready;
  logic [XLEN-1:0]  s2_pc, s2_opr_a, s2_opr_b, s2_opr_c;
  logic [4:0]       s2_rd, s2_unit, s2_op;
  logic             s2_op_w;
  logic [32:0]      s2_instr;
  logic [31:0]      perf_stall, perf_flush;

  core_pipe_issue dut (
    .g_clk(g_clk), .g_reset(g_reset), .flush(flush),
    .d_valid(d_valid), .d_ready(d_ready), .d_pc(d_pc),
    .d_rs1_addr(d_rs1_addr), .d_rs2_addr(d_rs2_addr),
    .d_rs1_use(d_rs1_use), .d_rs2_use(d_rs2_use), .d_rd(d_rd),
    .d_opr_a(d_opr_a), .d_opr_b(d_opr_b), .d_opr_c(d_opr_c),
    .d_unit(d_unit), .d_op(d_op), .d_op_w(d_op_w), .d_instr(d_instr),
    .wb_valid(wb_valid), .wb_rd(wb_rd),
    .s2_valid(s2_valid), .s3_ready(s3_ready),
    .s2_pc(s2_pc), .s2_opr_a(s2_opr_a), .s2_opr_b(s2_opr_b), .s2_opr_c(s2_opr_c),
    .s2_rd(s2_rd), .s2_unit(s2_unit), .s2_op(s2_op), .s2_op_w(s2_op_w),
    .s2_instr(s2_instr), .perf_stall(perf_stall), .perf_flush(perf_flush)
  );

  always #5 g_clk = ~g_clk;

  typedef struct {
    logic [63:0] pc, a, b, c;
    logic [4:0]  rs1, rs2, rd, unit, op;
    bit          u1, u2, op_w;
    logic [32:0] instr;
  } ins_t;

  int   total = 0;
  int   bad   = 0;
  ins_t q[$];
  bit   sb[32];
  int   m_stall, m_flush;
  ins_t cur;
  bit   dv;
  bit   last_ready;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic ins_t mk(input logic [63:0] pc, input logic [4:0] unit, input logic [4:0] rd,
                              input logic [4:0] rs1, input bit u1, input logic [4:0] rs2, input bit u2);
    ins_t x;
    x.pc = pc; x.unit = unit; x.rd = rd;
    x.rs1 = rs1; x.u1 = u1; x.rs2 = rs2; x.u2 = u2;
    x.a = {$urandom, $urandom}; x.b = {$urandom, $urandom}; x.c = {$urandom, $urandom};
    x.op = 5'($urandom); x.op_w = 1'($urandom); x.instr = {1'($urandom), $urandom};
    return x;
  endfunction

  // Model: register r waits on an unfinished long op, issued or still queued.
  function automatic bit pend(input logic [4:0] r);
    if (r == 0) return 0;
    if (sb[r]) return 1;
    foreach (q[i]) if (q[i].rd == r && (q[i].unit & LMASK) != 0) return 1;
    return 0;
  endfunction

  // One clock: drive, check outputs mid-cycle against the model, advance model.
  task automatic step();
    bit          hz, exp_rdy, deq, enq;
    ins_t        h;
    logic [31:0] exp_ps, exp_pf;
    d_valid = dv; d_pc = cur.pc; d_rs1_addr = cur.rs1; d_rs2_addr = cur.rs2;
    d_rs1_use = cur.u1; d_rs2_use = cur.u2; d_rd = cur.rd;
    d_opr_a = cur.a; d_opr_b = cur.b; d_opr_c = cur.c;
    d_unit = cur.unit; d_op = cur.op; d_op_w = cur.op_w; d_instr = cur.instr;
    @(negedge g_clk);
    hz = (cur.u1 && pend(cur.rs1)) || (cur.u2 && pend(cur.rs2)) || pend(cur.rd);
    exp_rdy = !flush && !hz && (q.size() < DEPTH);
    check("d_ready", d_ready, exp_rdy);
    check("s2_valid", s2_valid, q.size() != 0);
    last_ready = d_ready;
    if (q.size() != 0) begin
      h = q[0];
      check("s2_pc", s2_pc, h.pc);
      check("s2_opr_a", s2_opr_a, h.a);
      check("s2_opr_b", s2_opr_b, h.b);
      check("s2_opr_c", s2_opr_c, h.c);
      check("s2_ctl", {s2_rd, s2_unit, s2_op, s2_op_w, s2_instr},
            {h.rd, h.unit, h.op, h.op_w, h.instr});
    end
`ifdef CORE_ISSUE_PERF_EN
    exp_ps = 32'(m_stall); exp_pf = 32'(m_flush);
`else
    exp_ps = 0; exp_pf = 0;
`endif
    check("perf_stall", perf_stall, exp_ps);
    check("perf_flush", perf_flush, exp_pf);
    if (g_reset) begin
      q.delete();
      foreach (sb[i]) sb[i] = 0;
      m_stall = 0; m_flush = 0;
    end else begin
      deq = (q.size() != 0) && s3_ready;
      enq = dv && exp_rdy;
      if (dv && hz && !flush) m_stall++;
      if (flush) m_flush++;
      if (wb_valid) sb[wb_rd] = 0;
      if (deq) begin
        h = q.pop_front();
        if (h.rd != 0 && (h.unit & LMASK) != 0) sb[h.rd] = 1;
      end
      if (flush) q.delete();
      if (enq) q.push_back(cur);
    end
    @(posedge g_clk);
    #1;
  endtask

  initial begin
    int nstall;
    g_reset = 1; flush = 0; s3_ready = 1; wb_valid = 0; wb_rd = 0; dv = 0;
    cur = mk(64'h0, U_ALU, 5'd0, 5'd0, 0, 5'd0, 0);
    m_stall = 0; m_flush = 0;
    @(posedge g_clk); #1;
    step(); step();
    g_reset = 0;
    check("rst_s2_valid", s2_valid, 0);
    check("rst_s2_pc", s2_pc, 0);
    check("rst_s2_opr_a", s2_opr_a, 0);
    check("rst_s2_ctl", {s2_rd, s2_unit, s2_op, s2_op_w, s2_instr}, 0);

    // Back-to-back independent ALU ops.
    nstall = 0;
    for (int i = 0; i < 8; i++) begin
      cur = mk(64'h100 + 64'(4 * i), U_ALU, 5'(i + 1), 5'(i), 1, 5'(i + 2), 1);
      dv = 1; step();
      if (!last_ready) nstall++;
    end
    check("b2b_stalls", nstall, 0);
    dv = 0; step(); step();

    // Load-use: load rd=5 then add rs1=5; writeback on the fourth stall cycle.
    cur = mk(64'h200, U_LSU, 5'd5, 5'd0, 0, 5'd0, 0); dv = 1; step();
    cur = mk(64'h204, U_ALU, 5'd6, 5'd5, 1, 5'd0, 0);
    nstall = 0;
    for (int k = 0; k < 4; k++) begin
      wb_valid = (k == 3); wb_rd = 5; step();
      if (!last_ready) nstall++;
    end
    wb_valid = 0;
    check("loaduse_stalls", nstall, 4);
    step();
    check("loaduse_go", last_ready, 1);
    dv = 0; step(); step();

    // Backpressure: three ops against a stalled execute.
    s3_ready = 0;
    for (int i = 0; i < 4; i++) begin
      if (i < 3) cur = mk(64'h300 + 64'(4 * i), U_ALU, 5'(10 + i), 5'd0, 0, 5'd0, 0);
      dv = 1; step();
    end
    check("bp_hold_pc", s2_pc, 64'h300);
    check("bp_full", last_ready, 0);
    s3_ready = 1;
    step(); step();
    dv = 0; step(); step(); step();

    // Flush with two entries buffered; MDU rd=7 already issued.
    cur = mk(64'h400, U_MDU, 5'd7, 5'd0, 0, 5'd0, 0); dv = 1; step();
    dv = 0; step();
    s3_ready = 0; dv = 1;
    cur = mk(64'h404, U_ALU, 5'd11, 5'd0, 0, 5'd0, 0); step();
    cur = mk(64'h408, U_ALU, 5'd12, 5'd0, 0, 5'd0, 0); step();
    flush = 1;
    cur = mk(64'h40c, U_ALU, 5'd13, 5'd0, 0, 5'd0, 0); step();
    flush = 0;
    check("flush_empty", s2_valid, 0);
    check("flush_taken", last_ready, 0);
    cur = mk(64'h410, U_ALU, 5'd14, 5'd7, 1, 5'd0, 0); step();
    check("flush_sb7", last_ready, 0);
    dv = 0; s3_ready = 1;

    // Issue of MDU rd=9 coincides with a writeback to 9: bit stays set.
    cur = mk(64'h500, U_MDU, 5'd9, 5'd0, 0, 5'd0, 0); dv = 1; step();
    dv = 0; wb_valid = 1; wb_rd = 9; step();
    wb_valid = 0;
    cur = mk(64'h504, U_ALU, 5'd15, 5'd9, 1, 5'd0, 0); dv = 1; step();
    check("collide_b9", last_ready, 0);
    dv = 0; step();

    // x0 destination never stalls x0 readers.
    cur = mk(64'h600, U_MDU, 5'd0, 5'd0, 0, 5'd0, 0); dv = 1; step();
    cur = mk(64'h604, U_ALU, 5'd16, 5'd0, 1, 5'd0, 1); step();
    check("x0_ready", last_ready, 1);
    dv = 0; step();

    // Reset mid-drain clears buffer and scoreboard (bit 7 still set here).
    s3_ready = 0;
    cur = mk(64'h700, U_ALU, 5'd17, 5'd0, 0, 5'd0, 0); dv = 1; step();
    dv = 0; g_reset = 1; step();
    g_reset = 0;
    check("rst_mid_s2v", s2_valid, 0);
    cur = mk(64'h704, U_ALU, 5'd18, 5'd7, 1, 5'd9, 1); dv = 1; step();
    check("rst_sb_clear", last_ready, 1);
    dv = 0; s3_ready = 1; step();

    // Randomized traffic on a small register set to provoke hazards.
    for (int n = 0; n < 3000; n++) begin
      cur = mk(64'h1000 + 64'(4 * n), 5'(1 << $urandom_range(0, 4)), 5'($urandom_range(0, 7)),
               5'($urandom_range(0, 7)), 1'($urandom), 5'($urandom_range(0, 7)), 1'($urandom));
      dv       = ($urandom_range(0, 3) != 0);
      s3_ready = ($urandom_range(0, 3) != 0);
      wb_valid = ($urandom_range(0, 2) == 0);
      wb_rd    = 5'($urandom_range(0, 7));
      flush    = ($urandom_range(0, 19) == 0);
      g_reset  = ($urandom_range(0, 199) == 0);
      step();
    end
    g_reset = 0; flush = 0; dv = 0; wb_valid = 0;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
